// File: rtl/avalon_stream_loader_if.sv
// Byte-stream and Avalon-MM signal bundle for the stream loader.
// master: the loader side; slave: UART paths and memory side.
interface avalon_stream_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic [31:0]       readdata;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, tx_ready, readdata,
    output rx_ready, tx_data, tx_valid,
    output address, byteenable, chipselect, write,
    output writedata, clken, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, readdata,
    input  rx_ready, tx_data, tx_valid,
    input  address, byteenable, chipselect, write,
    input  writedata, clken, busy, err
  );
endinterface

// File: rtl/avalon_stream_loader.sv
// Parses framed byte packets and performs word writes/reads on an
// Avalon-MM memory, returning read words as a little-endian byte stream.
module avalon_stream_loader #(
  parameter int         ADDR_W    = 12,
  parameter int         DEPTH     = 2560,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_stream_loader_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_WR_COLLECT,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  logic              rx_en;
  logic              rx_fire;
  logic              tx_vld;
  logic              tx_fire;
  logic              cs;
  logic [15:0]       a16;
  logic [ADDR_W-1:0] a_new;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    rx_en = 1'b0;
    unique case (state_q)
      S_IDLE, S_CMD, S_ADDR_HI,
      S_ADDR_LO, S_COUNT,
      S_WR_COLLECT: rx_en = 1'b1;
      default:      rx_en = 1'b0;
    endcase
  end

  assign rx_fire  = bus.rx_valid & bus.rx_ready;
  assign tx_vld   = (state_q == S_RD_SEND);
  assign tx_fire  = tx_vld & bus.tx_ready;
  assign cs       = (state_q == S_WR_ISSUE)
                  | (state_q == S_RD_ISSUE);
  assign a16      = {hi_q, bus.rx_data};
  assign a_new    = ADDR_W'(a16);
  assign addr_inc = (addr_q == A_LAST)
                  ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      is_rd_q <= 1'b0;
      hi_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && bus.rx_data == SYNC_BYTE)
          state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_fire) begin
          if (bus.rx_data == 8'h01) begin
            is_rd_d = 1'b0;
            state_d = S_ADDR_HI;
          end else if (bus.rx_data == 8'h02) begin
            is_rd_d = 1'b1;
            state_d = S_ADDR_HI;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_fire) begin
          hi_d    = bus.rx_data;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_fire) begin
          if ({1'b0, a_new} < DEPTH_L) begin
            addr_d  = a_new;
            state_d = S_COUNT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_COUNT: begin
        if (rx_fire) begin
          cnt_d   = (bus.rx_data == 8'h00)
                  ? 9'd256 : {1'b0, bus.rx_data};
          idx_d   = '0;
          state_d = is_rd_q ? S_RD_ISSUE
                            : S_WR_COLLECT;
        end
      end
      S_WR_COLLECT: begin
        // Shift right so the first byte ends in bits [7:0]
        if (rx_fire) begin
          word_d = {bus.rx_data, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        addr_d  = addr_inc;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_IDLE
                                  : S_WR_COLLECT;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        word_d  = bus.readdata;
        idx_d   = '0;
        state_d = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (tx_fire) begin
          word_d = {8'h00, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = addr_inc;
            cnt_d   = cnt_q - 9'd1;
            state_d = (cnt_q == 9'd1) ? S_IDLE
                                      : S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_ready   = reset_n & rx_en;
  assign bus.tx_valid   = tx_vld;
  assign bus.tx_data    = tx_vld ? word_q[7:0] : 8'h00;
  assign bus.address    = addr_q;
  assign bus.byteenable = {4{cs}};
  assign bus.chipselect = cs;
  assign bus.write      = (state_q == S_WR_ISSUE);
  assign bus.writedata  = word_q;
  assign bus.clken      = 1'b1;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_avalon_stream_loader.sv
// Randomized bench for avalon_stream_loader against a packet-level
// model: expected writes, read strobes and tx bytes kept in queues.
module tb_avalon_stream_loader;
  localparam int AW    = 12;
  localparam int DEPTH = 2560;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  avalon_stream_loader_if #(.ADDR_W(AW)) bus();

  avalon_stream_loader #(
    .ADDR_W(AW), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [43:0] exp_wr[$];
  logic [11:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] fixed_q[$];
  int          n_strobe = 0;
  int          n_txb = 0;
  int          err_allow = 0;
  bit          cmp_on = 1'b0;
  int          txr_mode = 1;

  logic [31:0] model_mem[0:4095];
  logic [31:0] ram[0:4095];
  bit          ram_init = 1'b0;

  function automatic logic [31:0] pat(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not expected / bound expired", nm);
  endtask

  // Memory with read latency 1
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (bus.chipselect) begin
      if (bus.write) ram[bus.address] <= bus.writedata;
      else           bus.readdata <= ram[bus.address];
    end
  end

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = (txr_mode == 0) ? 1'($urandom_range(0, 1))
                                     : (txr_mode == 1);
    end
  end

  bit          prev_cs, prev_hold, prev_err;
  logic [7:0]  prev_tx;
  logic [1:0]  rd_sr;
  logic [43:0] ew;
  logic [7:0]  eb;

  always @(negedge clk) begin
    if (!reset_n || !cmp_on) begin
      prev_cs = 0; prev_hold = 0; prev_err = 0; rd_sr = '0;
    end else begin
      chk("clken", bus.clken, 1);
      chk("byteenable", bus.byteenable,
          bus.chipselect ? 4'hF : 4'h0);
      if (bus.chipselect) begin
        chk("cs_single_cycle", prev_cs, 0);
        if (bus.write) begin
          if (exp_wr.size() == 0) fail("unexpected_write");
          else begin
            ew = exp_wr.pop_front();
            chk("wr_addr", bus.address, ew[43:32]);
            chk("wr_data", bus.writedata, ew[31:0]);
          end
        end else begin
          n_strobe++;
          if (exp_rd.size() == 0) fail("unexpected_read");
          else chk("rd_addr", bus.address, exp_rd.pop_front());
        end
      end
      if (rd_sr[1]) chk("rd_latency_tx_valid", bus.tx_valid, 1);
      rd_sr = {rd_sr[0], bus.chipselect & ~bus.write};
      if (prev_hold) begin
        chk("tx_hold_valid", bus.tx_valid, 1);
        chk("tx_hold_data", bus.tx_data, prev_tx);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        n_txb++;
        tx_log.push_back(bus.tx_data);
        if (exp_tx.size() == 0) fail("unexpected_tx");
        else begin
          eb = exp_tx.pop_front();
          chk("tx_byte", bus.tx_data, eb);
        end
      end
      prev_hold = bus.tx_valid & ~bus.tx_ready;
      prev_tx = bus.tx_data;
      if (bus.err) begin
        chk("err_one_cycle", prev_err, 0);
        if (err_allow > 0) err_allow--;
        else fail("unexpected_err");
      end
      prev_err = bus.err;
      prev_cs = bus.chipselect;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) sync();
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rx_ready) fail("rx_ready_timeout");
    sync();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_tx.size() != 0 || exp_wr.size() != 0
            || exp_rd.size() != 0) && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20000) fail("idle_timeout");
    sync();
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [11:0] a,
                     input int n);
    logic [3:0] junk = 4'($urandom_range(0, 15));
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte({junk, a[11:8]});
    send_byte(a[7:0]);
    send_byte(8'(n));
  endtask

  task automatic do_write(input logic [11:0] a, input int n);
    logic [31:0] ws[$];
    logic [31:0] w;
    int ad = int'(a);
    for (int i = 0; i < n; i++) begin
      w = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom();
      ws.push_back(w);
      exp_wr.push_back({12'(ad), w});
      model_mem[ad] = w;
      ad = (ad + 1) % DEPTH;
    end
    hdr(8'h01, a, n);
    for (int i = 0; i < n; i++) begin
      w = ws[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
      @(negedge clk);
      chk("wr_issue_after_4th", {bus.chipselect, bus.write}, 2'b11);
      sync();
    end
  endtask

  task automatic do_read(input logic [11:0] a, input int n);
    logic [31:0] w;
    int ad = int'(a);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(12'(ad));
      w = model_mem[ad];
      for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
      ad = (ad + 1) % DEPTH;
    end
    hdr(8'h02, a, n);
  endtask

  task automatic bad_cmd(input logic [7:0] c);
    err_allow++;
    send_byte(8'hA5);
    send_byte(c);
    @(negedge clk);
    chk("err_bad_cmd", bus.err, 1);
    chk("idle_after_bad_cmd", bus.busy, 0);
    sync();
  endtask

  task automatic bad_addr(input logic [11:0] a);
    logic [3:0] junk = 4'($urandom_range(0, 15));
    err_allow++;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte({junk, a[11:8]});
    send_byte(a[7:0]);
    @(negedge clk);
    chk("err_bad_addr", bus.err, 1);
    chk("no_cs_bad_addr", bus.chipselect, 0);
    chk("idle_after_bad_addr", bus.busy, 0);
    sync();
  endtask

  task automatic chk_reset_outs();
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_byteenable", bus.byteenable, 0);
    chk("rst_chipselect", bus.chipselect, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_writedata", bus.writedata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_clken", bus.clken, 1);
  endtask

  initial begin
    int s0, t0, k;
    logic [7:0] c;
    logic [11:0] a;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    for (int i = 0; i < 4096; i++) model_mem[i] = pat(i);

    #3;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    sync();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_reset", bus.rx_ready, 1);
    sync();
    cmp_on = 1'b1;

    // Single write of DEADBEEF at 0x010
    fixed_q.push_back(32'hDEADBEEF);
    do_write(12'h010, 1);
    wait_idle();
    chk("ram_0x010", ram[16], 32'hDEADBEEF);

    // Read back with tx stalled for three cycles
    tx_log.delete();
    txr_mode = 2;
    do_read(12'h010, 1);
    k = 0;
    @(negedge clk);
    while (!bus.tx_valid && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("first_tx_byte", bus.tx_data, 8'hEF);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", bus.tx_valid, 1);
      chk("stall_data", bus.tx_data, 8'hEF);
    end
    sync();
    txr_mode = 1;
    wait_idle();
    chk("readback_len", tx_log.size(), 4);
    if (tx_log.size() == 4) begin
      chk("readback_b0", tx_log[0], 8'hEF);
      chk("readback_b1", tx_log[1], 8'hBE);
      chk("readback_b2", tx_log[2], 8'hAD);
      chk("readback_b3", tx_log[3], 8'hDE);
    end

    // Address wrap from the last word to zero
    fixed_q.push_back(32'h11223344);
    fixed_q.push_back(32'h55667788);
    do_write(12'h9FF, 2);
    wait_idle();
    chk("wrap_ram_9ff", ram[12'h9FF], 32'h11223344);
    chk("wrap_ram_000", ram[0], 32'h55667788);

    // Leading junk is discarded silently
    send_byte(8'h00);
    @(negedge clk);
    chk("junk00_idle", bus.busy, 0);
    sync();
    send_byte(8'hFF);
    @(negedge clk);
    chk("junkFF_idle", bus.busy, 0);
    sync();
    do_write(12'h123, 1);
    wait_idle();

    bad_cmd(8'h07);
    bad_addr(12'hA00);
    wait_idle();

    // COUNT=0 read: 256 words with random tx back-pressure
    txr_mode = 0;
    s0 = n_strobe;
    t0 = n_txb;
    do_read(12'($urandom_range(0, DEPTH - 1)), 256);
    wait_idle();
    chk("cnt0_bytes", n_txb - t0, 1024);
    chk("cnt0_strobes", n_strobe - s0, 256);
    chk("cnt0_busy_low", bus.busy, 0);

    // Reset in the middle of a write word
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    sync();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst2", bus.rx_ready, 1);
    chk("ram_0x020_untouched", ram[32], model_mem[32]);
    sync();
    do_write(12'h020, 1);
    do_read(12'h020, 1);
    wait_idle();

    // Randomized packet mix
    repeat (40) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        c = 8'($urandom());
        while (c == 8'h01 || c == 8'h02) c = 8'($urandom());
        bad_cmd(c);
      end else if (k == 1) begin
        bad_addr(12'($urandom_range(12'hA00, 12'hFFF)));
      end else if (k == 2) begin
        c = 8'($urandom());
        while (c == 8'hA5) c = 8'($urandom());
        send_byte(c);
      end else begin
        a = ($urandom_range(0, 3) == 0)
          ? 12'($urandom_range(DEPTH - 3, DEPTH - 1))
          : 12'($urandom_range(0, DEPTH - 1));
        if (k < 6) do_write(a, $urandom_range(1, 4));
        else       do_read(a, $urandom_range(1, 4));
      end
    end
    wait_idle();
    chk("err_pending", err_allow, 0);
    chk("final_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
